// File: rtl/difftest_commit_buffer.sv
// difftest_commit_buffer
//   Buffers the core's debug commit stream in a FIFO and drains it through a
//   valid/ready port. It also keeps the 64-bit cycle and instruction counters.
//   It detects the end-of-test trap instruction and reports the trap once
//   every older commit has drained.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   commit_*_i              committed instruction from the core
//                           (counted when valid & en)
//   out_ready_i / out_*_o   drain port; out_* show the FIFO head
//   cycle_cnt_o             cycles since reset
//   instr_cnt_o             entries delivered to the sink
//   trap_valid_o/code/pc    sticky trap report, raised once the trap entry pops
//   overflow_o              sticky; a commit was dropped on a full FIFO
//   level_o                 current FIFO occupancy
module difftest_commit_buffer #(
  parameter int unsigned DEPTH      = 8,
  parameter logic [31:0] TRAP_INSTR = 32'h8000_0000,
  parameter int unsigned CODE_REG   = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     commit_valid_i,
  input  logic                     commit_en_i,
  input  logic [31:0]              commit_pc_i,
  input  logic [31:0]              commit_instr_i,
  input  logic                     commit_wreg_i,
  input  logic [4:0]               commit_waddr_i,
  input  logic [31:0]              commit_wdata_i,
  input  logic                     out_ready_i,
  output logic                     out_valid_o,
  output logic [31:0]              out_pc_o,
  output logic [31:0]              out_instr_o,
  output logic                     out_wreg_o,
  output logic [4:0]               out_waddr_o,
  output logic [31:0]              out_wdata_o,
  output logic [63:0]              cycle_cnt_o,
  output logic [63:0]              instr_cnt_o,
  output logic                     trap_valid_o,
  output logic [7:0]               trap_code_o,
  output logic [31:0]              trap_pc_o,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [4:0]  CODE_IDX = 5'(CODE_REG);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } entry_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state;
  entry_t      mem [DEPTH];
  entry_t      head;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] level;
  logic        empty;
  logic        full;
  logic        acc;
  logic        pop;
  logic        push;
  logic        drop;
  logic        code_wr;
  logic        is_trap;
  logic [7:0]  shadow;

  always_comb begin
    level   = wr_ptr - rd_ptr;
    empty   = (wr_ptr == rd_ptr);
    full    = (level == (AW+1)'(DEPTH));
    acc     = commit_valid_i & commit_en_i & (state == RUN);
    pop     = ~empty & out_ready_i;
    // A full FIFO still takes a commit when the head leaves in the same cycle.
    push    = acc & (~full | pop);
    drop    = acc & full & ~pop;
    code_wr = push & commit_wreg_i & (commit_waddr_i == CODE_IDX)
              & (commit_waddr_i != 5'd0);
    is_trap = push & (commit_instr_i == TRAP_INSTR);
  end

  // Storage is not reset; after reset the pointers mark it as empty.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= '{pc:    commit_pc_i,
                               instr: commit_instr_i,
                               wreg:  commit_wreg_i,
                               waddr: commit_waddr_i,
                               wdata: commit_wdata_i};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cycle_cnt_o  <= '0;
      instr_cnt_o  <= '0;
      overflow_o   <= 1'b0;
      shadow       <= '0;
      trap_valid_o <= 1'b0;
      trap_code_o  <= '0;
      trap_pc_o    <= '0;
    end else begin
      cycle_cnt_o <= cycle_cnt_o + 64'd1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        instr_cnt_o <= instr_cnt_o + 64'd1;
      end
      if (drop) overflow_o <= 1'b1;
      // Only the low byte feeds the trap code.
      if (code_wr) shadow <= commit_wdata_i[7:0];

      case (state)
        RUN: begin
          // The trap code samples the shadow before this instruction's write.
          if (is_trap) begin
            trap_pc_o   <= commit_pc_i;
            trap_code_o <= shadow;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          // No pushes happen in DRAIN, so the pop at level 1 is the trap entry.
          if (pop && level == (AW+1)'(1)) begin
            state        <= HALT;
            trap_valid_o <= 1'b1;
          end
        end
        HALT: ;
        default: state <= RUN;
      endcase
    end
  end

  // Outputs read zero while the FIFO is empty, so reset clears them at once.
  always_comb begin
    head = empty ? '0 : mem[rd_ptr[AW-1:0]];
  end

  assign out_valid_o = ~empty;
  assign out_pc_o    = head.pc;
  assign out_instr_o = head.instr;
  assign out_wreg_o  = head.wreg;
  assign out_waddr_o = head.waddr;
  assign out_wdata_o = head.wdata;
  assign level_o     = level;

endmodule

// File: tb/tb_difftest_commit_buffer.sv
module tb_difftest_commit_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        commit_valid_i = 1'b0;
  logic        commit_en_i = 1'b0;
  logic [31:0] commit_pc_i = '0;
  logic [31:0] commit_instr_i = '0;
  logic        commit_wreg_i = 1'b0;
  logic [4:0]  commit_waddr_i = '0;
  logic [31:0] commit_wdata_i = '0;
  logic        out_ready_i = 1'b0;
  logic        out_valid_o;
  logic [31:0] out_pc_o;
  logic [31:0] out_instr_o;
  logic        out_wreg_o;
  logic [4:0]  out_waddr_o;
  logic [31:0] out_wdata_o;
  logic [63:0] cycle_cnt_o;
  logic [63:0] instr_cnt_o;
  logic        trap_valid_o;
  logic [7:0]  trap_code_o;
  logic [31:0] trap_pc_o;
  logic        overflow_o;
  logic [3:0]  level_o;

  int unsigned checks = 0;
  int unsigned failures = 0;
  longint unsigned cyc = 0;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] TRAP = 32'h8000_0000;

  difftest_commit_buffer #(
    .DEPTH(8),
    .TRAP_INSTR(32'h8000_0000),
    .CODE_REG(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .commit_valid_i(commit_valid_i),
    .commit_en_i(commit_en_i),
    .commit_pc_i(commit_pc_i),
    .commit_instr_i(commit_instr_i),
    .commit_wreg_i(commit_wreg_i),
    .commit_waddr_i(commit_waddr_i),
    .commit_wdata_i(commit_wdata_i),
    .out_ready_i(out_ready_i),
    .out_valid_o(out_valid_o),
    .out_pc_o(out_pc_o),
    .out_instr_o(out_instr_o),
    .out_wreg_o(out_wreg_o),
    .out_waddr_o(out_waddr_o),
    .out_wdata_o(out_wdata_o),
    .cycle_cnt_o(cycle_cnt_o),
    .instr_cnt_o(instr_cnt_o),
    .trap_valid_o(trap_valid_o),
    .trap_code_o(trap_code_o),
    .trap_pc_o(trap_pc_o),
    .overflow_o(overflow_o),
    .level_o(level_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic drive(input logic v, input logic en, input logic [31:0] pc,
                       input logic [31:0] instr, input logic wreg,
                       input logic [4:0] waddr, input logic [31:0] wdata);
    commit_valid_i = v;
    commit_en_i    = en;
    commit_pc_i    = pc;
    commit_instr_i = instr;
    commit_wreg_i  = wreg;
    commit_waddr_i = waddr;
    commit_wdata_i = wdata;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(out_valid_o), 64'd0);
    chk({tag, "_level"}, 64'(level_o), 64'd0);
    chk({tag, "_pc"}, 64'(out_pc_o), 64'd0);
    chk({tag, "_cycle"}, cycle_cnt_o, 64'd0);
    chk({tag, "_icnt"}, instr_cnt_o, 64'd0);
    chk({tag, "_trapv"}, 64'(trap_valid_o), 64'd0);
    chk({tag, "_trapc"}, 64'(trap_code_o), 64'd0);
    chk({tag, "_trappc"}, 64'(trap_pc_o), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow_o), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    cyc = 0;
    chk_all_zero("rst");
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #1;
    do_reset();

    // Steady flow: each commit shows up right after its edge, level stays 1.
    out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 32'h1c00_0000 + 32'(4 * i), NOP, 1'b0, 5'd0, 32'd0);
      tick();
      chk("flow_valid", 64'(out_valid_o), 64'd1);
      chk("flow_pc", 64'(out_pc_o), 64'(32'h1c00_0000 + 32'(4 * i)));
      chk("flow_level", 64'(level_o), 64'd1);
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, 5'd0, '0);
    tick();
    chk("flow_empty", 64'(level_o), 64'd0);
    chk("flow_icnt", instr_cnt_o, 64'd5);
    chk("flow_cycle", cycle_cnt_o, cyc);

    // Qualifier low: nothing is accepted.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h1c00_0f00, NOP, 1'b0, 5'd0, 32'd0);
      tick();
    end
    chk("qual_level", 64'(level_o), 64'd0);
    chk("qual_icnt", instr_cnt_o, 64'd5);
    chk("qual_cycle", cycle_cnt_o, cyc);

    // Backpressure: fill to 8.
    out_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 32'h1c00_1000 + 32'(4 * i), NOP, 1'b0, 5'd0, 32'd0);
      tick();
      chk("fill_level", 64'(level_o), 64'(i + 1));
    end
    chk("fill_ovf", 64'(overflow_o), 64'd0);
    chk("fill_head", 64'(out_pc_o), 64'h1c00_1000);

    // Full with simultaneous push and pop.
    drive(1'b1, 1'b1, 32'h1c00_1020, NOP, 1'b0, 5'd0, 32'd0);
    out_ready_i = 1'b1;
    tick();
    chk("pp_level", 64'(level_o), 64'd8);
    chk("pp_ovf", 64'(overflow_o), 64'd0);
    chk("pp_head", 64'(out_pc_o), 64'h1c00_1004);
    chk("pp_icnt", instr_cnt_o, 64'd6);

    // Two commits on a full FIFO with no pop are dropped.
    out_ready_i = 1'b0;
    drive(1'b1, 1'b1, 32'h1c00_1024, NOP, 1'b0, 5'd0, 32'd0);
    tick();
    chk("ovf_set", 64'(overflow_o), 64'd1);
    chk("ovf_level", 64'(level_o), 64'd8);
    drive(1'b1, 1'b1, 32'h1c00_1028, NOP, 1'b0, 5'd0, 32'd0);
    tick();
    chk("ovf_level2", 64'(level_o), 64'd8);

    // Drain: exactly entries 1..8 come out, then empty.
    drive(1'b0, 1'b0, '0, '0, 1'b0, 5'd0, '0);
    out_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_pc", 64'(out_pc_o), 64'(32'h1c00_1004 + 32'(4 * k)));
      tick();
    end
    chk("drain_level", 64'(level_o), 64'd0);
    chk("drain_valid", 64'(out_valid_o), 64'd0);
    chk("drain_icnt", instr_cnt_o, 64'd14);
    chk("drain_ovf", 64'(overflow_o), 64'd1);

    // Trap: r4=0x1234, r5 write, then trap that itself writes r4=0xFF.
    do_reset();
    out_ready_i = 1'b0;
    drive(1'b1, 1'b1, 32'h1c00_0080, NOP, 1'b1, 5'd4, 32'h0000_1234);
    tick();
    drive(1'b1, 1'b1, 32'h1c00_0084, NOP, 1'b1, 5'd5, 32'h0000_0099);
    tick();
    drive(1'b1, 1'b1, 32'h1c00_0100, TRAP, 1'b1, 5'd4, 32'h0000_00ff);
    tick();
    chk("trap_level", 64'(level_o), 64'd3);
    chk("trap_notyet", 64'(trap_valid_o), 64'd0);
    chk("trap_code_cap", 64'(trap_code_o), 64'h34);
    drive(1'b1, 1'b1, 32'h1c00_0200, NOP, 1'b0, 5'd0, 32'd0);
    tick();
    chk("trap_ignored", 64'(level_o), 64'd3);
    out_ready_i = 1'b1;
    tick();
    chk("trap_lvl2", 64'(level_o), 64'd2);
    chk("trap_wait1", 64'(trap_valid_o), 64'd0);
    tick();
    chk("trap_head_pc", 64'(out_pc_o), 64'h1c00_0100);
    chk("trap_head_ins", 64'(out_instr_o), 64'h8000_0000);
    chk("trap_head_wd", 64'(out_wdata_o), 64'hff);
    chk("trap_wait2", 64'(trap_valid_o), 64'd0);
    tick();
    chk("trap_valid", 64'(trap_valid_o), 64'd1);
    chk("trap_code", 64'(trap_code_o), 64'h34);
    chk("trap_pc", 64'(trap_pc_o), 64'h1c00_0100);
    chk("trap_icnt", instr_cnt_o, 64'd3);
    chk("trap_empty", 64'(level_o), 64'd0);
    tick();
    tick();
    chk("halt_level", 64'(level_o), 64'd0);
    chk("halt_ovf", 64'(overflow_o), 64'd0);
    chk("halt_sticky", 64'(trap_valid_o), 64'd1);
    chk("halt_cycle", cycle_cnt_o, cyc);

    // Reset in the middle of DRAIN with 3 entries buffered.
    do_reset();
    out_ready_i = 1'b0;
    drive(1'b1, 1'b1, 32'h1c00_0000, NOP, 1'b0, 5'd0, 32'd0);
    tick();
    drive(1'b1, 1'b1, 32'h1c00_0004, NOP, 1'b1, 5'd4, 32'h0000_0077);
    tick();
    drive(1'b1, 1'b1, 32'h1c00_0008, TRAP, 1'b0, 5'd0, 32'd0);
    tick();
    chk("md_level", 64'(level_o), 64'd3);
    chk("md_code", 64'(trap_code_o), 64'h77);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 5'd0, '0);
    do_reset();
    drive(1'b1, 1'b1, 32'h1c00_0300, NOP, 1'b0, 5'd0, 32'd0);
    tick();
    chk("post_level", 64'(level_o), 64'd1);
    chk("post_pc", 64'(out_pc_o), 64'h1c00_0300);
    chk("post_cycle", cycle_cnt_o, 64'd1);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 5'd0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
